// File: rtl/alu_ext_seq_pkg.sv
// Shared definitions for the extended-ALU issue/hold sequencer:
// extended-op function codes, sequencer state encoding and counter width.
package alu_ext_seq_pkg;

    // Counter width; every latency (1..15) minus one fits without wrap.
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FUNC_W = 3;

    // Extended-op function codes, as decoded by the extended ALU.
    typedef enum logic [FUNC_W-1:0] {
        FN_MUL   = 3'b000,
        FN_UMUL  = 3'b001,
        FN_ADDF  = 3'b010,
        FN_SUBF  = 3'b011,
        FN_MULF  = 3'b100,
        FN_ITF   = 3'b101,
        FN_FTI   = 3'b110,
        FN_UNDEF = 3'b111
    } func_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Every code except UNDEF is a real extended operation.
    function automatic logic is_legal_func(input logic [FUNC_W-1:0] f);
        return (f != FN_UNDEF);
    endfunction

endpackage

// File: rtl/alu_ext_seq_lat_lut.sv
// Combinational func -> hold latency lookup for the extended-ALU sequencer.
// The UNDEF code returns 1; it is never used because UNDEF is never accepted.
module alu_ext_seq_lat_lut #(
    parameter int unsigned LAT_IMUL = 2,
    parameter int unsigned LAT_FADD = 3,
    parameter int unsigned LAT_FMUL = 3,
    parameter int unsigned LAT_CVT  = 2
) (
    input  logic [2:0] i_func,
    output logic [3:0] o_lat
);
    import alu_ext_seq_pkg::*;

    // Map each function code onto its configured latency.
    always_comb begin
        o_lat = 4'd1;
        case (i_func)
            FN_MUL, FN_UMUL: o_lat = 4'(LAT_IMUL);
            FN_ADDF, FN_SUBF: o_lat = 4'(LAT_FADD);
            FN_MULF:          o_lat = 4'(LAT_FMUL);
            FN_ITF, FN_FTI:   o_lat = 4'(LAT_CVT);
            default:          o_lat = 4'd1;
        endcase
    end

endmodule

// File: rtl/alu_ext_seq.sv
// Issue/hold sequencer in front of the extended ALU.
// Accepts one extended op from ID/EX, holds operands/func for the op's latency
// while stalling the pipeline, then registers the ALU result and flags into the
// EX/DM stage with a one-cycle res_vld pulse.
// Build option: define ALU_EXT_OV_STICKY_EN to get a sticky overflow flag;
// without it ov_sticky is a constant 0.
module alu_ext_seq #(
    parameter int unsigned LAT_IMUL = 2,
    parameter int unsigned LAT_FADD = 3,
    parameter int unsigned LAT_FMUL = 3,
    parameter int unsigned LAT_CVT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic [2:0]  func,
    input  logic [31:0] src1,
    input  logic [31:0] src0,
    input  logic        flush,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src0,
    output logic [2:0]  alu_func,
    input  logic [31:0] alu_dst,
    input  logic        alu_ov,
    input  logic        alu_zr,
    input  logic        alu_neg,
    output logic        stall,
    output logic [31:0] dst_EX_DM,
    output logic        ov_EX_DM,
    output logic        zr_EX_DM,
    output logic        neg_EX_DM,
    output logic        res_vld,
    output logic        illegal_op,
    output logic        ov_sticky
);
    import alu_ext_seq_pkg::*;

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_lat;
    logic               w_issue_ok;
    logic               w_load;
    logic               w_capture;
    logic               w_stall;

    logic [31:0]        r_alu_src1;
    logic [31:0]        r_alu_src0;
    logic [2:0]         r_alu_func;
    logic [31:0]        r_dst;
    logic               r_ov;
    logic               r_zr;
    logic               r_neg;
    logic               r_res_vld;
    logic               r_illegal;

    alu_ext_seq_lat_lut #(
        .LAT_IMUL (LAT_IMUL),
        .LAT_FADD (LAT_FADD),
        .LAT_FMUL (LAT_FMUL),
        .LAT_CVT  (LAT_CVT)
    ) u_lat_lut (
        .i_func (func),
        .o_lat  (w_lat)
    );

    // A request is taken only when legal and not killed in the same cycle.
    assign w_issue_ok = issue && !flush && is_legal_func(func);

    // Next-state, counter and control decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_stall      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_issue_ok) begin
                    w_state_next = ST_BUSY;
                    w_cnt_next   = w_lat - 4'd1;
                    w_load       = 1'b1;
                    w_stall      = 1'b1;
                end
            end
            ST_BUSY: begin
                // Flush outranks completion when both land in one cycle.
                if (flush) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_capture    = !flush;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Operand/func hold registers; only reloaded when an op is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_src1 <= '0;
            r_alu_src0 <= '0;
            r_alu_func <= FN_MUL;
        end else if (w_load) begin
            r_alu_src1 <= src1;
            r_alu_src0 <= src0;
            r_alu_func <= func;
        end
    end

    // EX/DM result register; holds until the next unflushed completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dst <= '0;
            r_ov  <= 1'b0;
            r_zr  <= 1'b0;
            r_neg <= 1'b0;
        end else if (w_capture) begin
            r_dst <= alu_dst;
            r_ov  <= alu_ov;
            r_zr  <= alu_zr;
            r_neg <= alu_neg;
        end
    end

    // One-cycle status pulses: result valid and illegal-op report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_vld <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_res_vld <= w_capture;
            r_illegal <= (r_state == ST_IDLE) && issue && !is_legal_func(func);
        end
    end

`ifdef ALU_EXT_OV_STICKY_EN
    logic r_ov_sticky;

    // Sticky overflow: set by any captured overflow, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ov_sticky <= 1'b0;
        end else if (w_capture && alu_ov) begin
            r_ov_sticky <= 1'b1;
        end
    end

    assign ov_sticky = r_ov_sticky;
`else
    assign ov_sticky = 1'b0;
`endif

    assign stall      = w_stall;
    assign alu_src1   = r_alu_src1;
    assign alu_src0   = r_alu_src0;
    assign alu_func   = r_alu_func;
    assign dst_EX_DM  = r_dst;
    assign ov_EX_DM   = r_ov;
    assign zr_EX_DM   = r_zr;
    assign neg_EX_DM  = r_neg;
    assign res_vld    = r_res_vld;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_ext_seq.sv
// Self-checking bench for alu_ext_seq with a behavioural stub of the extended ALU.
// Honours ALU_EXT_OV_STICKY_EN the same way the design does.
module tb_alu_ext_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic [2:0]  func;
    logic [31:0] src1;
    logic [31:0] src0;
    logic        flush;
    logic [31:0] alu_src1;
    logic [31:0] alu_src0;
    logic [2:0]  alu_func;
    logic [31:0] alu_dst;
    logic        alu_ov;
    logic        alu_zr;
    logic        alu_neg;
    logic        stall;
    logic [31:0] dst_EX_DM;
    logic        ov_EX_DM;
    logic        zr_EX_DM;
    logic        neg_EX_DM;
    logic        res_vld;
    logic        illegal_op;
    logic        ov_sticky;

    int total = 0;
    int bad   = 0;

    // Model of architecturally visible state.
    logic [31:0] m_a, m_b, m_dst;
    logic [2:0]  m_f;
    logic        m_ov, m_zr, m_neg, m_sticky;

    typedef struct packed {
        logic        ov;
        logic        zr;
        logic        neg;
        logic [31:0] dst;
    } alu_res_t;

    always #5 clk = ~clk;

    alu_ext_seq dut (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .func       (func),
        .src1       (src1),
        .src0       (src0),
        .flush      (flush),
        .alu_src1   (alu_src1),
        .alu_src0   (alu_src0),
        .alu_func   (alu_func),
        .alu_dst    (alu_dst),
        .alu_ov     (alu_ov),
        .alu_zr     (alu_zr),
        .alu_neg    (alu_neg),
        .stall      (stall),
        .dst_EX_DM  (dst_EX_DM),
        .ov_EX_DM   (ov_EX_DM),
        .zr_EX_DM   (zr_EX_DM),
        .neg_EX_DM  (neg_EX_DM),
        .res_vld    (res_vld),
        .illegal_op (illegal_op),
        .ov_sticky  (ov_sticky)
    );

    // Single-precision bits -> real (normal numbers and zero only).
    function automatic real f2r(input logic [31:0] x);
        real r;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        r = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        for (int i = 0; i < e; i++) r = r * 2.0;
        for (int i = 0; i > e; i--) r = r / 2.0;
        return x[31] ? -r : r;
    endfunction

    // Real -> single-precision bits (truncating, in-range values only).
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural extended ALU.
    function automatic alu_res_t stub(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        alu_res_t          res;
        longint            p;
        longint unsigned   pu;
        logic [31:0]       lo;
        res = '0;
        case (f)
            3'b000: begin
                p = longint'($signed(a)) * longint'($signed(b));
                res.dst = p[31:0];
                lo = p[31:0];
                res.ov = (p != longint'($signed(lo)));
            end
            3'b001: begin
                pu = {32'd0, a} * {32'd0, b};
                res.dst = pu[31:0];
                res.ov = |pu[63:32];
            end
            3'b010: res.dst = r2f(f2r(a) + f2r(b));
            3'b011: res.dst = r2f(f2r(a) - f2r(b));
            3'b100: res.dst = r2f(f2r(a) * f2r(b));
            3'b101: res.dst = r2f(real'($signed(a)));
            3'b110: res.dst = $rtoi(f2r(a));
            default: res.dst = 32'd0;
        endcase
        res.zr  = (res.dst == 32'd0);
        res.neg = res.dst[31];
        return res;
    endfunction

    // Stub ALU sees whatever the sequencer presents.
    always_comb begin
        alu_res_t r;
        r = stub(alu_func, alu_src1, alu_src0);
        alu_dst = r.dst;
        alu_ov  = r.ov;
        alu_zr  = r.zr;
        alu_neg = r.neg;
    end

    function automatic int tb_lat(input logic [2:0] f);
        case (f)
            3'b000, 3'b001: return 2;
            3'b010, 3'b011: return 3;
            3'b100:         return 3;
            3'b101, 3'b110: return 2;
            default:        return 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Compare all held/registered outputs against the model.
    task automatic chk_state(input string ctx);
        chk({ctx, ":alu_src1"}, alu_src1, m_a);
        chk({ctx, ":alu_src0"}, alu_src0, m_b);
        chk({ctx, ":alu_func"}, 32'(alu_func), 32'(m_f));
        chk({ctx, ":dst"}, dst_EX_DM, m_dst);
        chk({ctx, ":flags"}, {29'd0, ov_EX_DM, zr_EX_DM, neg_EX_DM}, {29'd0, m_ov, m_zr, m_neg});
        chk({ctx, ":ov_sticky"}, 32'(ov_sticky), 32'(m_sticky));
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_f = 0; m_dst = 0;
        m_ov = 0; m_zr = 0; m_neg = 0; m_sticky = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; issue = 1'b0; flush = 1'b0; func = 3'd0; src1 = 0; src0 = 0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("rst:stall", 32'(stall), 32'd0);
        chk("rst:res_vld", 32'(res_vld), 32'd0);
        chk("rst:illegal", 32'(illegal_op), 32'd0);
        chk_state("rst");
    endtask

    // One transaction: issue at cycle 0, optional flush at cycle flush_cyc (-1 = none).
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int flush_cyc);
        int       lat;
        logic     legal, accepted, killed, exp_stall, exp_vld;
        alu_res_t exp_r;
        lat      = tb_lat(f);
        legal    = (f != 3'b111);
        accepted = legal && (flush_cyc != 0);
        killed   = accepted && (flush_cyc >= 1) && (flush_cyc <= lat + 1);
        exp_r    = stub(f, a, b);
        $display("op func=%b a=%h b=%h flush_cyc=%0d", f, a, b, flush_cyc);
        issue = 1'b1; func = f; src1 = a; src0 = b; flush = (flush_cyc == 0);
        #1;
        chk("c0:stall", 32'(stall), 32'(accepted));
        if (accepted) begin
            m_a = a; m_b = b; m_f = f;
        end
        for (int c = 1; c <= lat + 2; c++) begin
            @(posedge clk);
            #1;
            issue = 1'b0;
            func  = 3'($urandom);
            src1  = $urandom;
            src0  = $urandom;
            flush = (c == flush_cyc);
            #1;
            exp_stall = accepted && (c <= lat + 1) && !(killed && c > flush_cyc);
            exp_vld   = accepted && !killed && (c == lat + 2);
            if (exp_vld) begin
                m_dst = exp_r.dst; m_ov = exp_r.ov; m_zr = exp_r.zr; m_neg = exp_r.neg;
`ifdef ALU_EXT_OV_STICKY_EN
                if (exp_r.ov) m_sticky = 1'b1;
`endif
            end
            chk($sformatf("c%0d:stall", c), 32'(stall), 32'(exp_stall));
            chk($sformatf("c%0d:res_vld", c), 32'(res_vld), 32'(exp_vld));
            chk($sformatf("c%0d:illegal", c), 32'(illegal_op), 32'(!legal && c == 1));
            chk_state($sformatf("c%0d", c));
        end
        flush = 1'b0;
    endtask

    function automatic logic [31:0] rand_float(input int emin, input int emax);
        logic [7:0] e;
        e = 8'($urandom_range(emax, emin));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    function automatic logic [31:0] rand_operand(input logic [2:0] f);
        case (f)
            3'b010, 3'b011, 3'b100: return rand_float(110, 140);
            3'b101:                 return 32'($signed($urandom_range(2000000, 0)) - 1000000);
            3'b110:                 return rand_float(120, 145);
            default:                return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0] f;
        int         fc;
        rst = 1'b1; issue = 1'b0; flush = 1'b0; func = 3'd0; src1 = 0; src0 = 0;
        model_reset();

        do_reset(3);

        // Directed: ADDF 1.0 + 2.0 -> 3.0, res_vld at cycle 5.
        do_op(3'b010, 32'h3F80_0000, 32'h4000_0000, -1);
        chk("addf:dst", dst_EX_DM, 32'h4040_0000);

        // Directed: MUL 7 * -3.
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, -1);
        chk("mul:dst", dst_EX_DM, 32'hFFFF_FFEB);
        chk("mul:neg", 32'(neg_EX_DM), 32'd1);

        // Illegal op: pulse only, nothing else moves.
        do_op(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, -1);

        // MULF flushed in BUSY, then a new op must be accepted.
        do_op(3'b100, 32'h4040_0000, 32'h4080_0000, 2);
        do_op(3'b001, 32'd10, 32'd20, -1);

        // Flush together with issue: not accepted.
        do_op(3'b011, 32'h4000_0000, 32'h3F80_0000, 0);
        // Flush on the counter==0 cycle and on the DONE cycle.
        do_op(3'b010, 32'h3F80_0000, 32'h3F80_0000, 3);
        do_op(3'b010, 32'h3F80_0000, 32'h3F80_0000, 4);

        // Overflowing multiply followed by a clean one.
        do_op(3'b000, 32'h7FFF_FFFF, 32'd2, -1);
        do_op(3'b000, 32'd3, 32'd4, -1);

        // Randomised transactions.
        for (int n = 0; n < 40; n++) begin
            f  = 3'($urandom);
            fc = -1;
            if (f != 3'b111 && $urandom_range(3, 0) == 0)
                fc = int'($urandom_range(tb_lat(f) + 1, 0));
            do_op(f, rand_operand(f), rand_operand(f), fc);
        end

        // Reset in the middle of an op: aborted, no result.
        $display("op mid-op reset");
        issue = 1'b1; func = 3'b100; src1 = 32'h4000_0000; src0 = 32'h4000_0000;
        @(posedge clk);
        #1 issue = 1'b0;
        @(posedge clk);
        do_reset(1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #2;
            chk($sformatf("rstmid%0d:res_vld", c), 32'(res_vld), 32'd0);
            chk($sformatf("rstmid%0d:stall", c), 32'(stall), 32'd0);
            chk_state($sformatf("rstmid%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
